// File: rtl/fifo_drain_rr_arbiter_if.sv
// Source-FIFO and output-stream signals of the round-robin drain arbiter.
// master = arbiter side, slave = the FIFOs plus the downstream consumer.
interface fifo_drain_rr_arbiter_if #(
  parameter int NUM_PORTS     = 4,
  parameter int WIDTH         = 32,
  parameter int LOG_NUM_PORTS = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]       src_empty;
  logic [NUM_PORTS*WIDTH-1:0] src_q;
  logic [NUM_PORTS-1:0]       src_rdreq;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [LOG_NUM_PORTS-1:0]   out_port;
  logic                       out_ready;
  logic                       out_burst_end;

  modport master (
    input  src_empty, src_q, out_ready,
    output src_rdreq, out_valid, out_data, out_port, out_burst_end
  );

  modport slave (
    output src_empty, src_q, out_ready,
    input  src_rdreq, out_valid, out_data, out_port, out_burst_end
  );
endinterface

// File: rtl/fifo_drain_rr_arbiter.sv
// Drains NUM_PORTS show-ahead FIFOs round-robin (up to MAX_BURST grants per turn) into one
// registered valid/ready stage; a pop lands on out_valid one cycle later, held while stalled.
module fifo_drain_rr_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int LOG_NUM_PORTS = $clog2(NUM_PORTS),
  parameter int WIDTH         = 32,
  parameter int MAX_BURST     = 1,
  parameter int LOG_BURST     = $clog2(MAX_BURST + 1)
) (
  input  logic                    clock,
  input  logic                    rst,
  fifo_drain_rr_arbiter_if.master io
);
  localparam logic [LOG_BURST-1:0] MAX_CNT = LOG_BURST'(MAX_BURST);

  logic [LOG_NUM_PORTS-1:0] last_port_q, port_q, grant;
  logic [LOG_BURST-1:0]     burst_cnt_q, burst_cnt_d;
  logic [WIDTH-1:0]         data_q, head;
  logic                     valid_q, burst_end_q;
  logic [NUM_PORTS-1:0]     req;
  logic                     in_burst, found, load;
  int                       idx;

  assign req      = ~io.src_empty;
  assign in_burst = (burst_cnt_q != '0) && (burst_cnt_q < MAX_CNT);
  assign load     = ~rst & (~valid_q | io.out_ready) & (|req);

  always_comb begin
    grant = last_port_q;
    found = in_burst && req[last_port_q];
    idx   = 0;
    // Scan ends on last_port_q itself, so a lone requester keeps the grant.
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last_port_q) + i) % NUM_PORTS;
      if (!found && req[LOG_NUM_PORTS'(idx)]) begin
        grant = LOG_NUM_PORTS'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == LOG_NUM_PORTS'(i)) begin
        head = io.src_q[i*WIDTH +: WIDTH];
      end
    end
  end

  assign burst_cnt_d = (grant == last_port_q && in_burst) ? burst_cnt_q + 1'b1
                                                          : LOG_BURST'(1);

  assign io.src_rdreq     = load ? (NUM_PORTS'(1) << grant) : '0;
  assign io.out_valid     = valid_q;
  assign io.out_data      = data_q;
  assign io.out_port      = port_q;
  assign io.out_burst_end = burst_end_q;

  // Idle gaps leave burst_cnt_q alone, so a burst resumes where it stopped.
  always_ff @(posedge clock) begin
    if (rst) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      port_q      <= '0;
      burst_end_q <= 1'b0;
      last_port_q <= LOG_NUM_PORTS'(NUM_PORTS - 1);
      burst_cnt_q <= '0;
    end else if (load) begin
      valid_q     <= 1'b1;
      data_q      <= head;
      port_q      <= grant;
      burst_end_q <= (burst_cnt_d == MAX_CNT);
      last_port_q <= grant;
      burst_cnt_q <= burst_cnt_d;
    end else if (valid_q && io.out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifndef NO_DYNAMIC_ASSERTS
  a_rdreq_onehot0: assert property (@(posedge clock) $onehot0(io.src_rdreq));
  a_rdreq_nonempty: assert property (@(posedge clock) (io.src_rdreq & io.src_empty) == '0);
  a_hold_stable: assert property (@(posedge clock) disable iff (rst)
    (valid_q && !io.out_ready) |=> $stable(data_q));
`endif
endmodule
